// File: rtl/conv_output_collector_pkg.sv
// Shared types for the convolution output collector: result entry layout,
// collector FSM states and FIFO sizing helpers.
package conv_output_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int COORD_W_DEF = 32;

  typedef struct packed {
    logic [ACC_W_DEF-1:0]   data;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] ch;
  } result_entry_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    DONE    = 2'd2
  } collector_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/conv_output_collector_if.sv
// Controller-side capture, host-side result stream and status signals of the
// output collector; slave modport is the collector itself.
interface conv_output_collector_if #(
  parameter int ACC_WIDTH      = 32,
  parameter int COORD_WIDTH    = 32,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 16
);
  logic                      output_valid;
  logic [ACC_WIDTH-1:0]      out_data;
  logic [COORD_WIDTH-1:0]    output_x;
  logic [COORD_WIDTH-1:0]    output_y;
  logic [COORD_WIDTH-1:0]    output_ch;
  logic                      fsm_done;

  logic                      res_valid;
  logic                      res_ready;
  logic [ACC_WIDTH-1:0]      res_data;
  logic [COORD_WIDTH-1:0]    res_x;
  logic [COORD_WIDTH-1:0]    res_y;
  logic [COORD_WIDTH-1:0]    res_ch;

  logic [$clog2(DEPTH):0]    fill_level;
  logic                      overflow;
  logic [DROP_CNT_WIDTH-1:0] drop_count;
  logic                      clear_status;
  logic                      batch_done;

  modport master (
    output output_valid, out_data, output_x, output_y, output_ch, fsm_done,
           res_ready, clear_status,
    input  res_valid, res_data, res_x, res_y, res_ch,
           fill_level, overflow, drop_count, batch_done
  );

  modport slave (
    input  output_valid, out_data, output_x, output_y, output_ch, fsm_done,
           res_ready, clear_status,
    output res_valid, res_data, res_x, res_y, res_ch,
           fill_level, overflow, drop_count, batch_done
  );
endinterface

// File: rtl/conv_output_collector_sync_fifo.sv
// Single-clock FIFO with a registered show-ahead head; a push into an empty
// FIFO is visible on o_head the cycle after the write edge.
module sync_fifo
  import conv_output_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [cnt_w(DEPTH)-1:0] o_count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic [PW-1:0]    w_rptr_nxt;
  logic             w_push, w_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_pop      = i_pop && !o_empty;
  // A pop frees the slot the push lands in when full, so both can proceed.
  assign w_push     = i_push && (!o_full || w_pop);
  assign w_rptr_nxt = r_rptr + PW'(1);
  assign o_head     = r_head;
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Next head: the incoming word when nothing else is queued, otherwise
      // the entry behind the one leaving (never the slot written this edge).
      if (o_empty) begin
        if (w_push) r_head <= i_data;
      end else if (w_pop) begin
        if (r_count > CW'(1)) r_head <= r_mem[w_rptr_nxt];
        else if (w_push)      r_head <= i_data;
      end
    end
  end

endmodule

// File: rtl/conv_output_collector.sv
// Captures finished conv output pixels into a FIFO and streams them to the host.
// Build option CONV_OUTPUT_RELU_EN clamps negative results to zero on capture.
module conv_output_collector
  import conv_output_pkg::*;
#(
  parameter int ACC_WIDTH      = 32,
  parameter int COORD_WIDTH    = 32,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   arst_n_in,
  conv_output_collector_if.slave bus
);
  typedef struct packed {
    logic [ACC_WIDTH-1:0]   data;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] ch;
  } entry_t;

  localparam int EW = $bits(entry_t);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

  entry_t                    w_wr_entry, w_head;
  logic [ACC_WIDTH-1:0]      w_data_in;
  logic                      w_full, w_empty, w_push, w_pop, w_drop;
  logic [cnt_w(DEPTH)-1:0]   w_count;
  logic                      r_overflow, r_batch_done;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
  collector_state_t          r_state, w_state_nxt;

`ifdef CONV_OUTPUT_RELU_EN
  assign w_data_in = bus.out_data[ACC_WIDTH-1] ? '0 : bus.out_data;
`else
  assign w_data_in = bus.out_data;
`endif

  assign w_wr_entry = {w_data_in, bus.output_x, bus.output_y, bus.output_ch};
  assign w_pop      = !w_empty && bus.res_ready;
  assign w_push     = bus.output_valid && (!w_full || w_pop);
  // The controller cannot stall, so a capture into a full, non-draining FIFO is lost.
  assign w_drop     = bus.output_valid && w_full && !w_pop;

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .i_push    (w_push),
    .i_data    (w_wr_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign bus.res_valid  = !w_empty;
  assign bus.res_data   = w_head.data;
  assign bus.res_x      = w_head.x;
  assign bus.res_y      = w_head.y;
  assign bus.res_ch     = w_head.ch;
  assign bus.fill_level = w_count;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_cnt;
  assign bus.batch_done = r_batch_done;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (bus.clear_status) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  // FLUSH waits for an empty FIFO with no capture in flight; DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT: if (bus.fsm_done) w_state_nxt = FLUSH;
      FLUSH:   if (w_empty && !bus.output_valid) w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.fsm_done ? FLUSH : COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state      <= COLLECT;
      r_batch_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_batch_done <= (w_state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
// Randomized bench for conv_output_collector against a queue-based reference model.
module tb_conv_output_collector;
  import conv_output_pkg::*;

  localparam int DEPTH = 16;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  conv_output_collector_if #(.ACC_WIDTH(32), .COORD_WIDTH(32), .DEPTH(DEPTH),
                             .DROP_CNT_WIDTH(DCW)) bus();

  conv_output_collector #(.ACC_WIDTH(32), .COORD_WIDTH(32), .DEPTH(DEPTH),
                          .DROP_CNT_WIDTH(DCW)) dut (
    .clk       (clk),
    .arst_n_in (arst_n),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int bd_seen = 0;

  result_entry_t mq[$];
  bit m_ovf;
  int m_drops;
  bit m_wait, m_fire;

  always @(negedge clk) if (bus.batch_done === 1'b1) bd_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef CONV_OUTPUT_RELU_EN
    return d[31] ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_drops = 0; m_wait = 1'b0; m_fire = 1'b0;
  endtask

  task automatic check_all();
    chk("res_valid", 64'(bus.res_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("res_data", 64'(bus.res_data), 64'(mq[0].data));
      chk("res_x",    64'(bus.res_x),    64'(mq[0].x));
      chk("res_y",    64'(bus.res_y),    64'(mq[0].y));
      chk("res_ch",   64'(bus.res_ch),   64'(mq[0].ch));
    end
    chk("fill_level", 64'(bus.fill_level), 64'(mq.size()));
    chk("overflow",   64'(bus.overflow),   64'(m_ovf));
    chk("drop_count", 64'(bus.drop_count), 64'(m_drops));
    chk("batch_done", 64'(bus.batch_done), 64'(m_fire));
  endtask

  // Applies one clock edge worth of the spec's rules to the reference state.
  task automatic model_step(input bit ov, input logic [31:0] d, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ch,
                            input bit done, input bit rdy, input bit clr);
    int sz;
    bit pop, full, push, drop, nw, nf;
    result_entry_t e;
    sz   = mq.size();
    pop  = (sz > 0) && rdy;
    full = (sz == DEPTH);
    push = ov && (!full || pop);
    drop = ov && full && !pop;
    nw = m_wait; nf = 1'b0;
    if (m_fire) nw = done;
    else if (m_wait) begin
      if (sz == 0 && !ov) begin nw = 1'b0; nf = 1'b1; end
    end else if (done) nw = 1'b1;
    m_wait = nw; m_fire = nf;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.data = stored(d); e.x = x; e.y = y; e.ch = ch;
      mq.push_back(e);
    end
    if (clr) begin m_ovf = 1'b0; m_drops = 0; end
    else if (drop) begin m_ovf = 1'b1; if (m_drops < DMAX) m_drops++; end
  endtask

  // Called at a falling edge: check, drive, advance one cycle.
  task automatic cyc(input bit ov, input logic [31:0] d, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ch,
                     input bit done, input bit rdy, input bit clr);
    check_all();
    bus.output_valid = ov; bus.out_data = d;
    bus.output_x = x; bus.output_y = y; bus.output_ch = ch;
    bus.fsm_done = done; bus.res_ready = rdy; bus.clear_status = clr;
    @(posedge clk);
    model_step(ov, d, x, y, ch, done, rdy, clr);
    @(negedge clk);
  endtask

  task automatic push_rand(input bit rdy);
    cyc(1'b1, $urandom, $urandom, $urandom, 32'($urandom_range(0, 63)), 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int p_rdy;
    int bd0;
    bus.output_valid = 1'b0; bus.out_data = '0; bus.output_x = '0; bus.output_y = '0;
    bus.output_ch = '0; bus.fsm_done = 1'b0; bus.res_ready = 1'b0; bus.clear_status = 1'b0;
    model_reset();
    #12;
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    chk("rst_res_x",    64'(bus.res_x),    64'd0);
    check_all();
    @(negedge clk);
    arst_n = 1'b1;

    // single result
    cyc(1'b1, 32'h0000_0123, 32'd5, 32'd7, 32'd2, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 3);

    // backpressure: 16 fill, 17th dropped, drain in order
    for (int i = 0; i < 17; i++) push_rand(1'b0);
    idle(1'b1, 17);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_rand(1'b0);
    push_rand(1'b1);
    idle(1'b1, 17);

    // drop counter saturation, then clear wins over a simultaneous drop
    for (int i = 0; i < 36; i++) push_rand(1'b0);
    cyc(1'b1, 32'h55, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 17);

    // done drain with a second done absorbed during flush
    bd0 = bd_seen;
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 8);
    chk("bd_pulses", 64'(bd_seen - bd0), 64'd1);

    // sign handling of the stored accumulator value
    cyc(1'b1, 32'hFFFF_FFF6, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0009, 32'd4, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 3);

    // randomized traffic with varying host readiness
    p_rdy = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) p_rdy = 10 + 40 * int'($urandom_range(0, 2));
      cyc($urandom_range(0, 99) < 60, $urandom,
          32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), $urandom,
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < p_rdy,
          $urandom_range(0, 99) < 2);
    end
    idle(1'b1, 20);

    // reset mid-operation: 5 buffered entries, overflow set
    for (int i = 0; i < 17; i++) push_rand(1'b0);
    idle(1'b1, 11);
    chk("pre_rst_fill", 64'(bus.fill_level), 64'd5);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_valid",  64'(bus.res_valid),  64'd0);
    chk("arst_data",   64'(bus.res_data),   64'd0);
    chk("arst_ch",     64'(bus.res_ch),     64'd0);
    chk("arst_fill",   64'(bus.fill_level), 64'd0);
    chk("arst_ovf",    64'(bus.overflow),   64'd0);
    chk("arst_drops",  64'(bus.drop_count), 64'd0);
    chk("arst_bdone",  64'(bus.batch_done), 64'd0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    cyc(1'b1, 32'hCAFE_0001, 32'd9, 32'd8, 32'd7, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 3);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
